// File: rtl/nn_pkg.sv
// Shared constants and types for the MNIST frame loader and the network it feeds.
package nn_pkg;
  localparam int N_PIXELS    = 784;
  localparam int PIXEL_W     = 8;
  localparam int DATA_W      = 16;
  localparam int FRAC_SHIFT  = 7;
  localparam int TIMEOUT_CYC = 65536;

  typedef logic signed [DATA_W-1:0] nn_word_t;

  typedef enum logic [1:0] {
    LOAD,
    FIRE,
    WAIT
  } loader_state_t;
endpackage

// File: rtl/pixel_quantizer.sv
// Unsigned pixel to signed fixed-point word: left shift, saturating at the positive maximum.
module pixel_quantizer #(
  parameter int PIXEL_W    = nn_pkg::PIXEL_W,
  parameter int DATA_W     = nn_pkg::DATA_W,
  parameter int FRAC_SHIFT = nn_pkg::FRAC_SHIFT
) (
  input  logic [PIXEL_W-1:0] pixel_in,
  output logic [DATA_W-1:0]  word
);
  // Wide enough that neither the shifted pixel nor the limit is truncated.
  localparam int EXT_W = PIXEL_W + FRAC_SHIFT + DATA_W;

  logic [EXT_W-1:0] shifted;
  logic [EXT_W-1:0] max_pos;

  assign shifted = {{(FRAC_SHIFT + DATA_W){1'b0}}, pixel_in} << FRAC_SHIFT;
  assign max_pos = {{(EXT_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};

  always_comb begin
    word = shifted[DATA_W-1:0];
    if (shifted > max_pos) begin
      word = max_pos[DATA_W-1:0];
    end
  end
endmodule

// File: rtl/image_frame_loader.sv
// Collects one pixel frame into a register buffer, starts the network, then holds the
// buffer frozen until the network answers or the wait times out.
module image_frame_loader
  import nn_pkg::*;
#(
  parameter int N_PIXELS    = nn_pkg::N_PIXELS,
  parameter int PIXEL_W     = nn_pkg::PIXEL_W,
  parameter int DATA_W      = nn_pkg::DATA_W,
  parameter int FRAC_SHIFT  = nn_pkg::FRAC_SHIFT,
  parameter int TIMEOUT_CYC = nn_pkg::TIMEOUT_CYC
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PIXEL_W-1:0]               pixel_in,
  input  logic                             pixel_valid,
  input  logic                             pixel_last,
  output logic                             pixel_ready,
  output logic [N_PIXELS-1:0][DATA_W-1:0]  image_out,
  output logic                             nn_start,
  input  logic                             nn_valid_out,
  output logic                             busy,
  output logic                             frame_err,
  output logic                             timeout
);
  localparam int CNT_W  = $clog2(N_PIXELS);
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  loader_state_t     state;
  loader_state_t     state_next;
  logic [CNT_W-1:0]  pix_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DATA_W-1:0] word;
  logic              xfer;
  logic              at_end;

  pixel_quantizer #(
    .PIXEL_W    (PIXEL_W),
    .DATA_W     (DATA_W),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_quant (
    .pixel_in (pixel_in),
    .word     (word)
  );

  // pixel_ready is only ever high in LOAD, so it alone qualifies a transfer.
  assign xfer   = pixel_valid && pixel_ready;
  assign at_end = (pix_cnt == CNT_W'(N_PIXELS - 1));

  always_comb begin
    state_next = state;
    nn_start   = 1'b0;
    busy       = 1'b0;
    timeout    = 1'b0;
    case (state)
      LOAD: begin
        if (xfer && at_end && pixel_last) begin
          state_next = FIRE;
        end
      end
      FIRE: begin
        nn_start   = 1'b1;
        busy       = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (nn_valid_out) begin
          state_next = LOAD;
        end else if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) begin
          timeout    = 1'b1;
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= LOAD;
      pix_cnt     <= '0;
      wait_cnt    <= '0;
      pixel_ready <= 1'b0;
      frame_err   <= 1'b0;
      image_out   <= '0;
    end else begin
      state       <= state_next;
      pixel_ready <= (state_next == LOAD);
      frame_err   <= xfer && (pixel_last ^ at_end);
      wait_cnt    <= (state == WAIT && state_next == WAIT) ? wait_cnt + WAIT_W'(1) : '0;
      // A misaligned last still lands in the buffer; only the frame count restarts.
      if (xfer) begin
        image_out[pix_cnt] <= word;
        pix_cnt            <= (pixel_last || at_end) ? '0 : pix_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_image_frame_loader.sv
// Directed bench: instance A at default scaling, instance B with short timeout and shift 8.
module tb_image_frame_loader;
  localparam int NP = 784;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [7:0] pixel_in;
  logic pixel_last;
  logic valid_a, valid_b, nnv_a, nnv_b;
  logic ready_a, start_a, busy_a, ferr_a, tmo_a;
  logic ready_b, start_b, busy_b, ferr_b, tmo_b;
  logic [NP-1:0][15:0] img_a;
  logic [NP-1:0][15:0] img_b;

  image_frame_loader u_dut_a (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(valid_a), .pixel_last(pixel_last),
    .pixel_ready(ready_a), .image_out(img_a), .nn_start(start_a), .nn_valid_out(nnv_a),
    .busy(busy_a), .frame_err(ferr_a), .timeout(tmo_a)
  );

  image_frame_loader #(.TIMEOUT_CYC(16), .FRAC_SHIFT(8)) u_dut_b (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(valid_b), .pixel_last(pixel_last),
    .pixel_ready(ready_b), .image_out(img_b), .nn_start(start_b), .nn_valid_out(nnv_b),
    .busy(busy_b), .frame_err(ferr_b), .timeout(tmo_b)
  );

  int n_chk = 0;
  int n_pass = 0;
  int start_a_cnt = 0, ferr_a_cnt = 0, start_b_cnt = 0, tmo_b_cnt = 0;
  int exp_a[NP];
  int exp_b[NP];

  always @(posedge clk) begin
    if (start_a) start_a_cnt++;
    if (ferr_a)  ferr_a_cnt++;
    if (start_b) start_b_cnt++;
    if (tmo_b)   tmo_b_cnt++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic int pat(input int mode, input int i);
    case (mode)
      0:       return i % 256;
      1:       return 255;
      default: return 255 - (i % 256);
    endcase
  endfunction

  function automatic int quant(input int d, input int sh);
    int w;
    w = d << sh;
    return (w > 32767) ? 32767 : w;
  endfunction

  // Called and returns at a falling edge; returns once the pixel has been accepted.
  task automatic push(input bit sel_b, input int d, input bit last, input bit gap);
    int guard;
    bit acc;
    if (gap && ($urandom_range(0, 1) == 1)) begin
      if (sel_b) valid_b = 1'b0; else valid_a = 1'b0;
      @(negedge clk);
    end
    pixel_in   = d[7:0];
    pixel_last = last;
    if (sel_b) valid_b = 1'b1; else valid_a = 1'b1;
    guard = 0;
    while (1) begin
      acc = sel_b ? ready_b : ready_a;
      @(negedge clk);
      if (acc) break;
      guard++;
      if (guard > 100) begin
        chk("push_accept", {31'd0, acc}, 32'd1);
        break;
      end
    end
  endtask

  task automatic send_frame(input bit sel_b, input int mode, input int len, input int last_at,
                            input bit gap);
    for (int i = 0; i < len; i++) begin
      push(sel_b, pat(mode, i), (i == last_at), gap);
      if (sel_b) exp_b[i] = quant(pat(mode, i), 8);
      else       exp_a[i] = quant(pat(mode, i), 7);
    end
    valid_a    = 1'b0;
    valid_b    = 1'b0;
    pixel_last = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NP; i++) begin
      exp_a[i] = 0;
      exp_b[i] = 0;
    end
  endtask

  initial begin
    int s, e, found;
    bit rdy_seen;
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; nnv_a = 1'b0; nnv_b = 1'b0;
    pixel_in = '0; pixel_last = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);

    chk("rst_ready", {31'd0, ready_a}, 0);
    chk("rst_busy", {31'd0, busy_a}, 0);
    chk("rst_start", {31'd0, start_a}, 0);
    chk("rst_ferr", {31'd0, ferr_a}, 0);
    chk("rst_tmo", {31'd0, tmo_a}, 0);
    chk("rst_img_a", {31'd0, |img_a}, 0);
    chk("rst_img_b", {31'd0, |img_b}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, ready_a}, 1);

    // 1: ramp frame, start pulse one cycle after last
    s = start_a_cnt;
    send_frame(0, 0, NP, NP - 1, 0);
    chk("t1_start", {31'd0, start_a}, 1);
    chk("t1_busy_fire", {31'd0, busy_a}, 1);
    chk("t1_ready_fire", {31'd0, ready_a}, 0);
    @(negedge clk);
    chk("t1_start_single", {31'd0, start_a}, 0);
    chk("t1_busy_wait", {31'd0, busy_a}, 1);
    for (int i = 0; i < NP; i++) chk($sformatf("t1_img[%0d]", i), {16'd0, img_a[i]}, exp_a[i]);

    // 2: pixels offered in WAIT are refused, buffer frozen
    valid_a = 1'b1; pixel_in = 8'h11;
    rdy_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      rdy_seen = rdy_seen | ready_a;
    end
    chk("t2_ready_held", {31'd0, rdy_seen}, 0);
    chk("t2_busy", {31'd0, busy_a}, 1);
    chk("t2_img0", {16'd0, img_a[0]}, exp_a[0]);
    chk("t2_img300", {16'd0, img_a[300]}, exp_a[300]);
    chk("t2_img783", {16'd0, img_a[783]}, exp_a[783]);
    valid_a = 1'b0;
    nnv_a = 1'b1;
    @(negedge clk);
    nnv_a = 1'b0;
    chk("t2_turnaround", {31'd0, ready_a}, 1);
    chk("t2_busy_clear", {31'd0, busy_a}, 0);
    chk("t2_start_count", start_a_cnt, s + 1);

    // 3: early last -> frame_err, frame dropped, next frame from index 0
    s = start_a_cnt;
    e = ferr_a_cnt;
    send_frame(0, 0, 101, 100, 0);
    chk("t3_ferr", {31'd0, ferr_a}, 1);
    chk("t3_no_start", {31'd0, start_a}, 0);
    @(negedge clk);
    chk("t3_ferr_pulse", {31'd0, ferr_a}, 0);
    chk("t3_ready", {31'd0, ready_a}, 1);
    chk("t3_ferr_count", ferr_a_cnt, e + 1);
    send_frame(0, 2, NP, NP - 1, 0);
    chk("t3_start", {31'd0, start_a}, 1);
    chk("t3_start_count", start_a_cnt, s);
    chk("t3_img0", {16'd0, img_a[0]}, exp_a[0]);
    chk("t3_img100", {16'd0, img_a[100]}, exp_a[100]);
    chk("t3_img783", {16'd0, img_a[783]}, exp_a[783]);
    @(negedge clk);
    nnv_a = 1'b1;
    @(negedge clk);
    nnv_a = 1'b0;
    chk("t3_release", {31'd0, ready_a}, 1);

    // 4: instance B never answered -> timeout 16 cycles into WAIT
    s = tmo_b_cnt;
    send_frame(1, 0, NP, NP - 1, 0);
    chk("t4_start", {31'd0, start_b}, 1);
    chk("t4_img1", {16'd0, img_b[1]}, 256);
    chk("t4_img127", {16'd0, img_b[127]}, 32512);
    chk("t4_img128", {16'd0, img_b[128]}, 32767);
    chk("t4_img255", {16'd0, img_b[255]}, 32767);
    found = 0;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (tmo_b) begin
        found = j;
        break;
      end
    end
    chk("t4_timeout_cycle", found, 16);
    @(negedge clk);
    chk("t4_tmo_pulse", {31'd0, tmo_b}, 0);
    chk("t4_ready", {31'd0, ready_b}, 1);
    chk("t4_busy", {31'd0, busy_b}, 0);
    chk("t4_tmo_count", tmo_b_cnt, s + 1);

    // 5b: shift 8 saturates every full-scale pixel
    send_frame(1, 1, NP, NP - 1, 0);
    for (int i = 0; i < NP; i++) chk($sformatf("t5_sat[%0d]", i), {16'd0, img_b[i]}, exp_b[i]);
    repeat (20) @(negedge clk);
    chk("t5_tmo_count", tmo_b_cnt, s + 2);

    // 5a: gappy valid, full-scale pixels on A
    s = start_a_cnt;
    send_frame(0, 1, NP, NP - 1, 1);
    @(negedge clk);
    for (int i = 0; i < NP; i++) chk($sformatf("t5_img[%0d]", i), {16'd0, img_a[i]}, 32640);
    chk("t5_start_once", start_a_cnt, s + 1);
    nnv_a = 1'b1;
    @(negedge clk);
    nnv_a = 1'b0;

    // 6: reset mid-frame and again during WAIT
    send_frame(0, 0, 400, -1, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ready", {31'd0, ready_a}, 0);
    chk("t6_busy", {31'd0, busy_a}, 0);
    chk("t6_start", {31'd0, start_a}, 0);
    chk("t6_img", {31'd0, |img_a}, 0);
    clear_model();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready_back", {31'd0, ready_a}, 1);
    s = start_a_cnt;
    send_frame(0, 0, NP, NP - 1, 0);
    chk("t6_start_full", {31'd0, start_a}, 1);
    @(negedge clk);
    chk("t6_busy_wait", {31'd0, busy_a}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_busy_rst", {31'd0, busy_a}, 0);
    chk("t6_ready_rst", {31'd0, ready_a}, 0);
    chk("t6_img_rst", {31'd0, |img_a}, 0);
    rst = 1'b0;
    nnv_a = 1'b1;
    @(negedge clk);
    nnv_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_late_valid", start_a_cnt, s + 1);
    chk("t6_busy_late", {31'd0, busy_a}, 0);
    chk("t6_ready_late", {31'd0, ready_a}, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
